// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: FSM states and
// set-2 scan-code constants.
package ps2_kbd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;

endpackage

// File: rtl/ps2_kbd_ctrl_ascii_map.sv
// Combinational scan-code (set 2) to ASCII lookup. Letters honour 'upper',
// digits are always the plain digit, a few control keys map to their codes.
module ps2_ascii_map
  import ps2_kbd_ctrl_pkg::*;
(
  input  logic [7:0] code,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  // Lookup: letters resolve to lowercase first, then case is applied.
  always_comb begin
    letter = 8'h00;
    ascii  = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; // a
      8'h32: letter = 8'h62; // b
      8'h21: letter = 8'h63; // c
      8'h23: letter = 8'h64; // d
      8'h24: letter = 8'h65; // e
      8'h2B: letter = 8'h66; // f
      8'h34: letter = 8'h67; // g
      8'h33: letter = 8'h68; // h
      8'h43: letter = 8'h69; // i
      8'h3B: letter = 8'h6A; // j
      8'h42: letter = 8'h6B; // k
      8'h4B: letter = 8'h6C; // l
      8'h3A: letter = 8'h6D; // m
      8'h31: letter = 8'h6E; // n
      8'h44: letter = 8'h6F; // o
      8'h4D: letter = 8'h70; // p
      8'h15: letter = 8'h71; // q
      8'h2D: letter = 8'h72; // r
      8'h1B: letter = 8'h73; // s
      8'h2C: letter = 8'h74; // t
      8'h3C: letter = 8'h75; // u
      8'h2A: letter = 8'h76; // v
      8'h1D: letter = 8'h77; // w
      8'h22: letter = 8'h78; // x
      8'h35: letter = 8'h79; // y
      8'h1A: letter = 8'h7A; // z
      8'h45: ascii  = 8'h30;
      8'h16: ascii  = 8'h31;
      8'h1E: ascii  = 8'h32;
      8'h26: ascii  = 8'h33;
      8'h25: ascii  = 8'h34;
      8'h2E: ascii  = 8'h35;
      8'h36: ascii  = 8'h36;
      8'h3D: ascii  = 8'h37;
      8'h3E: ascii  = 8'h38;
      8'h46: ascii  = 8'h39;
      SC_SPACE: ascii = ASC_SPACE;
      SC_ENTER: ascii = ASC_CR;
      SC_BKSP:  ascii = ASC_BS;
      default: ascii = 8'h00;
    endcase
    if (letter != 8'h00) ascii = upper ? (letter - 8'h20) : letter;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code decoder. Pops bytes from the receiver FIFO at most
// once every three cycles, folds E0/F0 prefixes into the following code and
// publishes one key event per non-prefix byte together with modifier state.
module ps2_kbd_ctrl
  import ps2_kbd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       kb_ready,
  input  logic [7:0] kb_data,
  input  logic       kb_overflow,
  output logic       nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_release,
  output logic       key_ext,
  output logic       key_repeat,
  output logic       shift,
  output logic       ctrl,
  output logic       caps,
  output logic [7:0] key_count,
  output logic       ovf
);

  state_t     state_q, state_d;
  logic       ext_pend, brk_pend;
  logic [8:0] last_make;

  logic       take;
  logic       is_e0, is_f0, is_make, is_rpt, hit_last;
  logic       is_shift_code, is_ctrl_code, is_caps_code;
  logic [8:0] code9;
  logic [7:0] map_ascii;

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and pop strobe; GAP keeps kb_ready unsampled right after a pop.
  always_comb begin
    state_d    = state_q;
    nextdata_n = 1'b1;
    case (state_q)
      ST_IDLE: if (kb_ready) state_d = ST_TAKE;
      ST_TAKE: begin
        nextdata_n = 1'b0;
        state_d    = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode of the byte being popped, using state from before this event.
  always_comb begin
    take          = (state_q == ST_TAKE);
    is_e0         = (kb_data == SC_E0);
    is_f0         = (kb_data == SC_F0);
    is_make       = !brk_pend;
    code9         = {ext_pend, kb_data};
    hit_last      = (code9 == last_make);
    is_rpt        = is_make && hit_last;
    is_shift_code = !ext_pend && ((kb_data == SC_LSHIFT) || (kb_data == SC_RSHIFT));
    is_ctrl_code  = (kb_data == SC_CTRL);
    is_caps_code  = !ext_pend && (kb_data == SC_CAPS);
  end

  ps2_ascii_map u_map (
    .code  (kb_data),
    .upper (shift ^ caps),
    .ascii (map_ascii)
  );

  // Event and modifier registers, loaded on the TAKE->GAP edge so the event
  // is visible during GAP; this replaces a separate byte-holding register.
  always_ff @(posedge clk) begin
    if (clr) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_ascii   <= '0;
      key_release <= 1'b0;
      key_ext     <= 1'b0;
      key_repeat  <= 1'b0;
      shift       <= 1'b0;
      ctrl        <= 1'b0;
      caps        <= 1'b0;
      key_count   <= '0;
      ovf         <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      last_make   <= '0;
    end else begin
      key_valid <= 1'b0;
      if (kb_overflow) ovf <= 1'b1;
      if (take) begin
        if (is_e0) begin
          ext_pend <= 1'b1;
        end else if (is_f0) begin
          brk_pend <= 1'b1;
        end else begin
          key_valid   <= 1'b1;
          key_code    <= kb_data;
          key_ascii   <= (brk_pend || ext_pend) ? 8'h00 : map_ascii;
          key_release <= brk_pend;
          key_ext     <= ext_pend;
          key_repeat  <= is_rpt;
          ext_pend    <= 1'b0;
          brk_pend    <= 1'b0;
          if (is_make) begin
            if (!is_rpt) begin
              last_make <= code9;
              key_count <= key_count + 8'd1;
              if (is_caps_code) caps <= ~caps;
            end
          end else if (hit_last) begin
            last_make <= '0;
          end
          if (is_shift_code) shift <= is_make;
          if (is_ctrl_code)  ctrl  <= is_make;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl with a behavioural receiver FIFO.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       kb_ready;
  logic [7:0] kb_data;
  logic       kb_overflow;
  logic       nextdata_n, key_valid;
  logic [7:0] key_code, key_ascii, key_count;
  logic       key_release, key_ext, key_repeat, shift, ctrl, caps, ovf;

  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       rel;
    logic       ext;
    logic       rpt;
    logic       sh;
    logic       ct;
    logic       cp;
  } ev_t;

  ev_t ev_q[$];
  int  pop_q[$];
  int  cyc = 0;
  int  overlap = 0;
  int  n_tests = 0;
  int  n_fail = 0;

  logic [7:0] mem [0:1023];
  int wr = 0;
  int rd = 0;

  assign kb_ready = (rd != wr);
  assign kb_data  = mem[rd % 1024];

  ps2_kbd_ctrl dut (
    .clk(clk), .clr(clr), .kb_ready(kb_ready), .kb_data(kb_data),
    .kb_overflow(kb_overflow), .nextdata_n(nextdata_n), .key_valid(key_valid),
    .key_code(key_code), .key_ascii(key_ascii), .key_release(key_release),
    .key_ext(key_ext), .key_repeat(key_repeat), .shift(shift), .ctrl(ctrl),
    .caps(caps), .key_count(key_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Receiver FIFO pops on the edge where the strobe is low.
  always @(posedge clk) if (nextdata_n === 1'b0) rd <= rd + 1;

  // Monitor: log events, pop cycles, and event/pop overlaps.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (key_valid === 1'b1)
      ev_q.push_back('{key_code, key_ascii, key_release, key_ext, key_repeat, shift, ctrl, caps});
    if (nextdata_n === 1'b0) pop_q.push_back(cyc);
    if (key_valid === 1'b1 && nextdata_n === 1'b0) overlap <= overlap + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    mem[wr % 1024] = b;
    wr = wr + 1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (rd != wr && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rd != wr) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d bytes left, required 0", wr - rd);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    kb_overflow = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (nextdata_n !== 1'b1) begin n_fail++; $display("FAIL rst_nextdata_n: got %b want 1", nextdata_n); end
    n_tests++;
    if ({key_valid, key_release, key_ext, key_repeat, shift, ctrl, caps} !== 7'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0000000",
        {key_valid, key_release, key_ext, key_repeat, shift, ctrl, caps});
    end
    n_tests++;
    if ({key_code, key_ascii, key_count} !== 24'h0) begin
      n_fail++; $display("FAIL rst_bytes: got %h want 000000", {key_code, key_ascii, key_count});
    end
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf_priority: got %b want 0", ovf); end
    kb_overflow = 1'b0;
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    do_reset();
    push(8'h1C);
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0", key_valid); end
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b1 || key_code !== 8'h1C) begin
      n_fail++; $display("FAIL lat_event: valid %b code %h want 1 1c", key_valid, key_code);
    end
    @(negedge clk);
    n_tests++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pulse_width: got %b want 0", key_valid); end
    wait_idle(50);
  endtask

  task automatic test_make_break();
    int n0;
    do_reset();
    n0 = ev_q.size();
    push(8'h1C); push(8'hF0); push(8'h1C);
    wait_idle(100);
    n_tests++;
    if (ev_q.size() - n0 != 2) begin
      n_fail++; $display("FAIL mb_events: got %0d want 2", ev_q.size() - n0);
    end else begin
      n_tests++;
      if (ev_q[n0].code !== 8'h1C || ev_q[n0].ascii !== 8'h61 || ev_q[n0].rel !== 1'b0) begin
        n_fail++; $display("FAIL mb_make: code %h ascii %h rel %b want 1c 61 0",
          ev_q[n0].code, ev_q[n0].ascii, ev_q[n0].rel);
      end
      n_tests++;
      if (ev_q[n0+1].code !== 8'h1C || ev_q[n0+1].rel !== 1'b1 || ev_q[n0+1].ascii !== 8'h00) begin
        n_fail++; $display("FAIL mb_break: code %h rel %b ascii %h want 1c 1 00",
          ev_q[n0+1].code, ev_q[n0+1].rel, ev_q[n0+1].ascii);
      end
    end
    n_tests++;
    if (key_count !== 8'd1) begin n_fail++; $display("FAIL mb_count: got %0d want 1", key_count); end
  endtask

  task automatic test_shift();
    int n0;
    do_reset();
    n0 = ev_q.size();
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
    wait_idle(100);
    n_tests++;
    if (ev_q.size() - n0 != 4) begin
      n_fail++; $display("FAIL sh_events: got %0d want 4", ev_q.size() - n0);
    end else begin
      n_tests++;
      if (ev_q[n0+1].ascii !== 8'h41) begin
        n_fail++; $display("FAIL sh_upper: got %h want 41", ev_q[n0+1].ascii);
      end
      n_tests++;
      if ({ev_q[n0].sh, ev_q[n0+1].sh, ev_q[n0+2].sh, ev_q[n0+3].sh} !== 4'b1110) begin
        n_fail++; $display("FAIL sh_state: got %b want 1110",
          {ev_q[n0].sh, ev_q[n0+1].sh, ev_q[n0+2].sh, ev_q[n0+3].sh});
      end
    end
    n_tests++;
    if (shift !== 1'b0 || key_count !== 8'd2) begin
      n_fail++; $display("FAIL sh_final: shift %b count %0d want 0 2", shift, key_count);
    end
  endtask

  task automatic test_caps_repeat();
    int n0;
    do_reset();
    n0 = ev_q.size();
    push(8'h58); push(8'hF0); push(8'h58); push(8'h1C); push(8'h1C);
    wait_idle(100);
    n_tests++;
    if (ev_q.size() - n0 != 4) begin
      n_fail++; $display("FAIL cp_events: got %0d want 4", ev_q.size() - n0);
    end else begin
      n_tests++;
      if (ev_q[n0+2].ascii !== 8'h41 || ev_q[n0+2].rpt !== 1'b0) begin
        n_fail++; $display("FAIL cp_first: ascii %h rpt %b want 41 0", ev_q[n0+2].ascii, ev_q[n0+2].rpt);
      end
      n_tests++;
      if (ev_q[n0+3].ascii !== 8'h41 || ev_q[n0+3].rpt !== 1'b1) begin
        n_fail++; $display("FAIL cp_repeat: ascii %h rpt %b want 41 1", ev_q[n0+3].ascii, ev_q[n0+3].rpt);
      end
    end
    n_tests++;
    if (caps !== 1'b1 || key_count !== 8'd2) begin
      n_fail++; $display("FAIL cp_final: caps %b count %0d want 1 2", caps, key_count);
    end
  endtask

  task automatic test_ext_ctrl();
    int n0;
    do_reset();
    n0 = ev_q.size();
    push(8'hE0); push(8'h14); push(8'hE0); push(8'hF0); push(8'h14);
    wait_idle(100);
    n_tests++;
    if (ev_q.size() - n0 != 2) begin
      n_fail++; $display("FAIL ext_events: got %0d want 2", ev_q.size() - n0);
    end else begin
      n_tests++;
      if ({ev_q[n0].ext, ev_q[n0].rel, ev_q[n0].ct} !== 3'b101 || ev_q[n0].ascii !== 8'h00) begin
        n_fail++; $display("FAIL ext_make: ext/rel/ctrl %b ascii %h want 101 00",
          {ev_q[n0].ext, ev_q[n0].rel, ev_q[n0].ct}, ev_q[n0].ascii);
      end
      n_tests++;
      if ({ev_q[n0+1].ext, ev_q[n0+1].rel, ev_q[n0+1].ct} !== 3'b110 || ev_q[n0+1].ascii !== 8'h00) begin
        n_fail++; $display("FAIL ext_break: ext/rel/ctrl %b ascii %h want 110 00",
          {ev_q[n0+1].ext, ev_q[n0+1].rel, ev_q[n0+1].ct}, ev_q[n0+1].ascii);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0, p0, o0;
    do_reset();
    n0 = ev_q.size();
    p0 = pop_q.size();
    o0 = overlap;
    push(8'h1C); push(8'h32); push(8'h21);
    wait_idle(100);
    n_tests++;
    if (pop_q.size() - p0 != 3) begin
      n_fail++; $display("FAIL b2b_pops: got %0d want 3", pop_q.size() - p0);
    end else begin
      n_tests++;
      if (pop_q[p0+1] - pop_q[p0] != 3 || pop_q[p0+2] - pop_q[p0+1] != 3) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3",
          pop_q[p0+1] - pop_q[p0], pop_q[p0+2] - pop_q[p0+1]);
      end
    end
    n_tests++;
    if (overlap != o0) begin n_fail++; $display("FAIL b2b_pop_in_gap: got %0d want 0", overlap - o0); end
    n_tests++;
    if (ev_q.size() - n0 != 3) begin
      n_fail++; $display("FAIL b2b_events: got %0d want 3", ev_q.size() - n0);
    end else begin
      n_tests++;
      if ({ev_q[n0].ascii, ev_q[n0+1].ascii, ev_q[n0+2].ascii} !== 24'h616263) begin
        n_fail++; $display("FAIL b2b_order: got %h want 616263",
          {ev_q[n0].ascii, ev_q[n0+1].ascii, ev_q[n0+2].ascii});
      end
    end
  endtask

  task automatic test_abort_ovf();
    int n0;
    do_reset();
    n0 = ev_q.size();
    push(8'hF0);
    @(negedge clk);   // TAKE
    @(negedge clk);   // GAP
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_tests++;
    if (ev_q.size() != n0 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL ab_no_event: events %0d valid %b want 0 0", ev_q.size() - n0, key_valid);
    end
    push(8'h1C);
    wait_idle(50);
    n_tests++;
    if (ev_q.size() - n0 != 1) begin
      n_fail++; $display("FAIL ab_events: got %0d want 1", ev_q.size() - n0);
    end else begin
      n_tests++;
      if (ev_q[n0].code !== 8'h1C || ev_q[n0].rel !== 1'b0) begin
        n_fail++; $display("FAIL ab_prefix_lost: code %h rel %b want 1c 0", ev_q[n0].code, ev_q[n0].rel);
      end
    end
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got %b want 0", ovf); end
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    do_reset();
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 257; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
    wait_idle(2000);
    n_tests++;
    if (key_count !== 8'd1) begin n_fail++; $display("FAIL count_wrap: got %0d want 1", key_count); end
  endtask

  initial begin
    clr = 1'b1;
    kb_overflow = 1'b0;
    test_reset();
    test_latency();
    test_make_break();
    test_shift();
    test_caps_repeat();
    test_ext_ctrl();
    test_back_to_back();
    test_abort_ovf();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
